// File: rtl/counter_mod_gl_if.sv
// Control/status bundle for counter_mod_gl: the master drives the controls and the slave returns count and tc.
interface counter_mod_gl_if;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc;

    modport master (output en, up, load, load_val, input count, tc);
    modport slave  (input en, up, load, load_val, output count, tc);
endinterface

// File: rtl/counter_mod_gl.sv
// 4-bit modulo up/down counter built from gate primitives around resettable D flip-flops.
// Build with COUNTER_MOD_SAT_EN defined to saturate at p_max/0 instead of wrapping.

module dff_r (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    always_ff @(posedge clk) begin
        if (rst) q_o <= 1'b0;
        else     q_o <= d_i;
    end
endmodule

module mux2_gl (
    input  logic a_i,
    input  logic b_i,
    input  logic s_i,
    output logic y_o
);
    logic s_n, a_sel, b_sel;

    not g_sn (s_n, s_i);
    and g_a  (a_sel, a_i, s_n);
    and g_b  (b_sel, b_i, s_i);
    or  g_y  (y_o, a_sel, b_sel);
endmodule

module counter_mod_gl #(
    parameter logic [3:0] p_max = 4'd15
) (
    input logic             clk,
    input logic             rst,
    counter_mod_gl_if.slave bus
);
    localparam logic [3:0] ONE = 4'd1;

    logic       en_i, up_i, load_i, up_n;
    logic [3:0] load_val_i;
    logic [3:0] count_q, count_d;
    logic [3:0] addend, sum, carry, max_bit;
    logic [3:0] wrap_val, step, en_val;
    logic       eq_max, eq_zero, wrap;

    assign en_i       = bus.en;
    assign up_i       = bus.up;
    assign load_i     = bus.load;
    assign load_val_i = bus.load_val;

    // One ripple chain for both directions: down uses 0001^1111 = 1110 plus carry-in 1, i.e. -1.
    not g_upn (up_n, up_i);
    buf g_cin (carry[0], up_n);

    for (genvar i = 0; i < 4; i++) begin : g_bit
        logic prop;

        xor  g_addend (addend[i], ONE[i], up_n);
        xor  g_prop   (prop, count_q[i], addend[i]);
        xor  g_sum    (sum[i], prop, carry[i]);
        xnor g_cmp    (max_bit[i], count_q[i], p_max[i]);

        if (i < 3) begin : g_carry
            logic gen_ab, prop_c;
            and g_gen  (gen_ab, count_q[i], addend[i]);
            and g_pc   (prop_c, prop, carry[i]);
            or  g_cout (carry[i+1], gen_ab, prop_c);
        end

`ifdef COUNTER_MOD_SAT_EN
        buf g_wrapv (wrap_val[i], count_q[i]);
`else
        and g_wrapv (wrap_val[i], up_n, p_max[i]);
`endif

        mux2_gl u_wrap (.a_i(sum[i]),    .b_i(wrap_val[i]),   .s_i(wrap),   .y_o(step[i]));
        mux2_gl u_en   (.a_i(count_q[i]), .b_i(step[i]),      .s_i(en_i),   .y_o(en_val[i]));
        mux2_gl u_load (.a_i(en_val[i]), .b_i(load_val_i[i]), .s_i(load_i), .y_o(count_d[i]));

        dff_r u_ff (.clk(clk), .rst(rst), .d_i(count_d[i]), .q_o(count_q[i]));
    end

    and g_eqmax  (eq_max, max_bit[0], max_bit[1], max_bit[2], max_bit[3]);
    nor g_eqzero (eq_zero, count_q[0], count_q[1], count_q[2], count_q[3]);

    // The terminal-count condition doubles as the wrap select.
    mux2_gl u_tc (.a_i(eq_zero), .b_i(eq_max), .s_i(up_i), .y_o(wrap));

    assign bus.count = count_q;
    assign bus.tc    = wrap;
endmodule

// File: tb/tb_counter_mod_gl.sv
// Directed bench for counter_mod_gl: three instances with p_max = 15, 9 and 0 share clock and reset.
module tb_counter_mod_gl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    counter_mod_gl_if if15 ();
    counter_mod_gl_if if9 ();
    counter_mod_gl_if if0 ();

    counter_mod_gl #(.p_max(4'd15)) dut15 (.clk(clk), .rst(rst), .bus(if15));
    counter_mod_gl #(.p_max(4'd9))  dut9  (.clk(clk), .rst(rst), .bus(if9));
    counter_mod_gl #(.p_max(4'd0))  dut0  (.clk(clk), .rst(rst), .bus(if0));

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_all;
        if15.en = 1'b0; if15.up = 1'b1; if15.load = 1'b0; if15.load_val = 4'd0;
        if9.en  = 1'b0; if9.up  = 1'b1; if9.load  = 1'b0; if9.load_val  = 4'd0;
        if0.en  = 1'b0; if0.up  = 1'b1; if0.load  = 1'b0; if0.load_val  = 4'd0;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_all();
        @(negedge clk);
        pulse_reset();
        n_vec++; if (if15.count !== 4'd0) begin n_err++; $display("FAIL reset_count15: got %0d want 0", if15.count); end
        n_vec++; if (if9.count !== 4'd0) begin n_err++; $display("FAIL reset_count9: got %0d want 0", if9.count); end
        n_vec++; if (if0.count !== 4'd0) begin n_err++; $display("FAIL reset_count0: got %0d want 0", if0.count); end
        n_vec++; if (if15.tc !== 1'b0) begin n_err++; $display("FAIL reset_tc15_up: got %b want 0", if15.tc); end
        n_vec++; if (if0.tc !== 1'b1) begin n_err++; $display("FAIL reset_tc0_up: got %b want 1", if0.tc); end
        if15.up = 1'b0;
        #1;
        n_vec++; if (if15.tc !== 1'b1) begin n_err++; $display("FAIL reset_tc15_down: got %b want 1", if15.tc); end
        if15.up = 1'b1;
    endtask

    task automatic test_count_up_15;
        logic [3:0] exp_tbl [17] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                                     4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
        pulse_reset();
        if15.en = 1'b1; if15.up = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            n_vec++;
            if (if15.count !== exp_tbl[k]) begin
                n_err++; $display("FAIL up15_count step %0d: got %0d want %0d", k, if15.count, exp_tbl[k]);
            end
            n_vec++;
            if (if15.tc !== (exp_tbl[k] == 4'd15)) begin
                n_err++; $display("FAIL up15_tc step %0d: got %b want %b", k, if15.tc, exp_tbl[k] == 4'd15);
            end
        end
        if15.en = 1'b0;
    endtask

    task automatic test_down_wrap_15;
        pulse_reset();
        if15.en = 1'b1; if15.up = 1'b0;
        #1;
        n_vec++; if (if15.tc !== 1'b1) begin n_err++; $display("FAIL down15_tc_at0: got %b want 1", if15.tc); end
        tick();
        n_vec++; if (if15.count !== 4'd15) begin n_err++; $display("FAIL down15_wrap: got %0d want 15", if15.count); end
        n_vec++; if (if15.tc !== 1'b0) begin n_err++; $display("FAIL down15_tc_at15: got %b want 0", if15.tc); end
        tick();
        n_vec++; if (if15.count !== 4'd14) begin n_err++; $display("FAIL down15_dec: got %0d want 14", if15.count); end
        if15.en = 1'b0; if15.up = 1'b1;
    endtask

    task automatic test_mod10;
        logic [3:0] up_tbl [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
        logic [3:0] dn_tbl [4]  = '{4'd9, 4'd8, 4'd7, 4'd6};
        pulse_reset();
        if9.en = 1'b1; if9.up = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if (if9.count !== up_tbl[k]) begin
                n_err++; $display("FAIL mod10_up step %0d: got %0d want %0d", k, if9.count, up_tbl[k]);
            end
            n_vec++;
            if (if9.tc !== (up_tbl[k] == 4'd9)) begin
                n_err++; $display("FAIL mod10_up_tc step %0d: got %b want %b", k, if9.tc, up_tbl[k] == 4'd9);
            end
        end
        if9.up = 1'b0;
        #1;
        n_vec++; if (if9.tc !== 1'b1) begin n_err++; $display("FAIL mod10_tc_follows_up: got %b want 1", if9.tc); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if (if9.count !== dn_tbl[k]) begin
                n_err++; $display("FAIL mod10_down step %0d: got %0d want %0d", k, if9.count, dn_tbl[k]);
            end
            n_vec++;
            if (if9.tc !== 1'b0) begin
                n_err++; $display("FAIL mod10_down_tc step %0d: got %b want 0", k, if9.tc);
            end
        end
        if9.en = 1'b0; if9.up = 1'b1;
    endtask

    task automatic test_load_priority;
        pulse_reset();
        if15.en = 1'b1; if15.up = 1'b1;
        repeat (5) tick();
        n_vec++; if (if15.count !== 4'd5) begin n_err++; $display("FAIL loadpri_pre: got %0d want 5", if15.count); end
        if15.load = 1'b1; if15.load_val = 4'd12;
        tick();
        n_vec++; if (if15.count !== 4'd12) begin n_err++; $display("FAIL loadpri_load: got %0d want 12", if15.count); end
        if15.load = 1'b0;
        tick();
        n_vec++; if (if15.count !== 4'd13) begin n_err++; $display("FAIL loadpri_after: got %0d want 13", if15.count); end
        if15.en = 1'b0;
        repeat (2) tick();
        n_vec++; if (if15.count !== 4'd13) begin n_err++; $display("FAIL loadpri_hold: got %0d want 13", if15.count); end
    endtask

    task automatic test_reset_priority;
        if15.load = 1'b1; if15.load_val = 4'd7;
        tick();
        if15.load = 1'b0;
        n_vec++; if (if15.count !== 4'd7) begin n_err++; $display("FAIL rstpri_pre: got %0d want 7", if15.count); end
        rst = 1'b1; if15.load = 1'b1; if15.load_val = 4'd3; if15.en = 1'b1;
        tick();
        rst = 1'b0; if15.load = 1'b0; if15.en = 1'b0;
        n_vec++; if (if15.count !== 4'd0) begin n_err++; $display("FAIL rstpri_reset: got %0d want 0", if15.count); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (if15.count !== 4'd0) begin n_err++; $display("FAIL rstpri_hold step %0d: got %0d want 0", k, if15.count); end
        end
    endtask

    task automatic test_out_of_range;
        logic [3:0] exp_tbl [13] = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3,
                                     4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        if9.en = 1'b1; if9.up = 1'b1; if9.load = 1'b1; if9.load_val = 4'd12;
        tick();
        if9.load = 1'b0;
        n_vec++; if (if9.count !== 4'd12) begin n_err++; $display("FAIL oor_load: got %0d want 12", if9.count); end
        for (int k = 0; k < 13; k++) begin
            tick();
            n_vec++;
            if (if9.count !== exp_tbl[k]) begin
                n_err++; $display("FAIL oor_up step %0d: got %0d want %0d", k, if9.count, exp_tbl[k]);
            end
            n_vec++;
            if (if9.tc !== (exp_tbl[k] == 4'd9)) begin
                n_err++; $display("FAIL oor_up_tc step %0d: got %b want %b", k, if9.tc, exp_tbl[k] == 4'd9);
            end
        end
        if9.up = 1'b0; if9.load = 1'b1; if9.load_val = 4'd12;
        tick();
        if9.load = 1'b0;
        n_vec++; if (if9.tc !== 1'b0) begin n_err++; $display("FAIL oor_down_tc: got %b want 0", if9.tc); end
        tick();
        n_vec++; if (if9.count !== 4'd11) begin n_err++; $display("FAIL oor_down: got %0d want 11", if9.count); end
        if9.en = 1'b0; if9.up = 1'b1;
    endtask

    task automatic test_saturation;
`ifdef COUNTER_MOD_SAT_EN
        logic [3:0] up_tbl [3] = '{4'd9, 4'd9, 4'd9};
        logic [3:0] dn_tbl [2] = '{4'd0, 4'd0};
`else
        logic [3:0] up_tbl [3] = '{4'd9, 4'd0, 4'd1};
        logic [3:0] dn_tbl [2] = '{4'd0, 4'd9};
`endif
        if9.load = 1'b1; if9.load_val = 4'd8;
        tick();
        if9.load = 1'b0; if9.en = 1'b1; if9.up = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (if9.count !== up_tbl[k]) begin
                n_err++; $display("FAIL edge_up step %0d: got %0d want %0d", k, if9.count, up_tbl[k]);
            end
        end
        if9.en = 1'b0; if9.load = 1'b1; if9.load_val = 4'd1;
        tick();
        if9.load = 1'b0; if9.en = 1'b1; if9.up = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            if (if9.count !== dn_tbl[k]) begin
                n_err++; $display("FAIL edge_down step %0d: got %0d want %0d", k, if9.count, dn_tbl[k]);
            end
        end
        if9.en = 1'b0; if9.up = 1'b1;
    endtask

    task automatic test_pmax_zero;
        pulse_reset();
        if0.en = 1'b1; if0.up = 1'b1;
        tick();
        n_vec++; if (if0.count !== 4'd0) begin n_err++; $display("FAIL pmax0_up: got %0d want 0", if0.count); end
        n_vec++; if (if0.tc !== 1'b1) begin n_err++; $display("FAIL pmax0_up_tc: got %b want 1", if0.tc); end
        if0.up = 1'b0;
        tick();
        n_vec++; if (if0.count !== 4'd0) begin n_err++; $display("FAIL pmax0_down: got %0d want 0", if0.count); end
        n_vec++; if (if0.tc !== 1'b1) begin n_err++; $display("FAIL pmax0_down_tc: got %b want 1", if0.tc); end
        if0.load = 1'b1; if0.load_val = 4'd5;
        tick();
        if0.load = 1'b0;
        n_vec++; if (if0.tc !== 1'b0) begin n_err++; $display("FAIL pmax0_tc_at5: got %b want 0", if0.tc); end
        if0.up = 1'b1;
        tick();
        n_vec++; if (if0.count !== 4'd6) begin n_err++; $display("FAIL pmax0_oor_up: got %0d want 6", if0.count); end
        if0.en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up_15();
        test_down_wrap_15();
        test_mod10();
        test_load_priority();
        test_reset_priority();
        test_out_of_range();
        test_saturation();
        test_pmax_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
